// File: rtl/trigger_ctrl.sv
// Trigger sequencer: prefill, slope or auto-timeout trigger, wait for frame transfer, holdoff.
// Optional hysteresis qualifier on the slope trigger is compiled in by defining TRIG_HYST_EN.
module trigger_ctrl #(
    parameter int SAMPLE_WIDTH   = 12,
    parameter int PRETRIG        = 1024,
    parameter int HOLDOFF_CYCLES = 2500,
    parameter int AUTO_TIMEOUT   = 2500000,
    parameter int HYST           = 16
) (
    input  logic                    i_clk,
    input  logic                    i_RESET,
    input  logic                    i_sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
    input  logic [SAMPLE_WIDTH-1:0] i_trig_level,
    input  logic                    i_trig_slope,
    input  logic [1:0]              i_mode,
    input  logic                    i_arm,
    input  logic                    i_transfer_done,
    output logic                    o_trigger,
    output logic                    o_auto_trig,
    output logic                    o_armed,
    output logic                    o_busy,
    output logic [2:0]              o_state,
    output logic [15:0]             o_trig_count
);

    localparam int PW = $clog2(PRETRIG + 1);
    localparam int AW = $clog2(AUTO_TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRETRIG - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] MODE_STOP   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        ARMED     = 3'd2,
        WAIT_XFER = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           preCnt_q, preCnt_d;
    logic [AW-1:0]           autoCnt_q, autoCnt_d;
    logic [HW-1:0]           holdCnt_q, holdCnt_d;
    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic                    prevValid_q, prevValid_d;
    logic                    trig_q, trig_d;
    logic                    autoTrig_q, autoTrig_d;
    logic [15:0]             trigCount_q, trigCount_d;

    logic modeRun;
    logic modeStop;
    logic riseHit;
    logic fallHit;
    logic edgeHit;
    logic timeoutHit;

    assign modeRun    = (i_mode == MODE_NORMAL) || (i_mode == MODE_AUTO);
    assign modeStop   = (i_mode == MODE_STOP);
    assign timeoutHit = (i_mode == MODE_AUTO) && (autoCnt_q == AUTO_LAST);

`ifdef TRIG_HYST_EN
    logic                    lowSeen_q, lowSeen_d;
    logic                    highSeen_q, highSeen_d;
    logic [SAMPLE_WIDTH:0]   hiSum;
    logic [SAMPLE_WIDTH-1:0] loThr;
    logic [SAMPLE_WIDTH-1:0] hiThr;
    logic                    lowNow;
    logic                    highNow;

    // Band edges saturate so a level near either rail still has a reachable qualifier.
    always_comb begin
        hiSum   = {1'b0, i_trig_level} + (SAMPLE_WIDTH + 1)'(HYST);
        hiThr   = hiSum[SAMPLE_WIDTH] ? '1 : hiSum[SAMPLE_WIDTH-1:0];
        loThr   = ({1'b0, i_trig_level} >= (SAMPLE_WIDTH + 1)'(HYST))
                  ? (i_trig_level - SAMPLE_WIDTH'(HYST)) : '0;
        lowNow  = i_sample_data <= loThr;
        highNow = i_sample_data >= hiThr;
    end
`else
    if (HYST < 0) begin : gHystUnused
    end
`endif

    always_comb begin
        riseHit = prevValid_q && (prev_q < i_trig_level) && (i_sample_data >= i_trig_level);
        fallHit = prevValid_q && (prev_q > i_trig_level) && (i_sample_data <= i_trig_level);
`ifdef TRIG_HYST_EN
        riseHit = riseHit && (lowSeen_q || lowNow);
        fallHit = fallHit && (highSeen_q || highNow);
`endif
        edgeHit = i_sample_valid && (i_trig_slope ? fallHit : riseHit);
    end

    always_comb begin
        state_d     = state_q;
        preCnt_d    = preCnt_q;
        autoCnt_d   = autoCnt_q;
        holdCnt_d   = holdCnt_q;
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        trig_d      = 1'b0;
        autoTrig_d  = 1'b0;
        trigCount_d = trigCount_q;
`ifdef TRIG_HYST_EN
        lowSeen_d   = lowSeen_q;
        highSeen_d  = highSeen_q;
`endif
        case (state_q)
            IDLE: begin
                if (modeRun || ((i_mode == MODE_SINGLE) && i_arm)) begin
                    state_d     = PREFILL;
                    preCnt_d    = '0;
                    prevValid_d = 1'b0;
                end
            end
            PREFILL: begin
                if (modeStop) begin
                    state_d = IDLE;
                end else if (i_sample_valid) begin
                    if (preCnt_q == PRE_LAST) begin
                        state_d     = ARMED;
                        autoCnt_d   = '0;
                        prevValid_d = 1'b0;
`ifdef TRIG_HYST_EN
                        lowSeen_d   = 1'b0;
                        highSeen_d  = 1'b0;
`endif
                    end else begin
                        preCnt_d = preCnt_q + PW'(1);
                    end
                end
            end
            ARMED: begin
                if (modeStop) begin
                    state_d = IDLE;
                end else begin
                    if (i_sample_valid) begin
                        prev_d      = i_sample_data;
                        prevValid_d = 1'b1;
`ifdef TRIG_HYST_EN
                        lowSeen_d   = lowSeen_q | lowNow;
                        highSeen_d  = highSeen_q | highNow;
`endif
                    end
                    // Saturate so a later switch into AUTO fires promptly instead of wrapping.
                    if (autoCnt_q != AUTO_LAST) begin
                        autoCnt_d = autoCnt_q + AW'(1);
                    end
                    if (edgeHit || timeoutHit) begin
                        trig_d      = 1'b1;
                        autoTrig_d  = ~edgeHit;
                        trigCount_d = trigCount_q + 16'd1;
                        state_d     = WAIT_XFER;
                    end
                end
            end
            WAIT_XFER: begin
                if (i_transfer_done) begin
                    state_d   = HOLDOFF;
                    holdCnt_d = '0;
                end
            end
            HOLDOFF: begin
                if (modeStop) begin
                    state_d = IDLE;
                end else if (holdCnt_q == HOLD_LAST) begin
                    if (modeRun) begin
                        state_d     = PREFILL;
                        preCnt_d    = '0;
                        prevValid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    holdCnt_d = holdCnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q     <= IDLE;
            preCnt_q    <= '0;
            autoCnt_q   <= '0;
            holdCnt_q   <= '0;
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            trig_q      <= 1'b0;
            autoTrig_q  <= 1'b0;
            trigCount_q <= '0;
`ifdef TRIG_HYST_EN
            lowSeen_q   <= 1'b0;
            highSeen_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            preCnt_q    <= preCnt_d;
            autoCnt_q   <= autoCnt_d;
            holdCnt_q   <= holdCnt_d;
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
            trig_q      <= trig_d;
            autoTrig_q  <= autoTrig_d;
            trigCount_q <= trigCount_d;
`ifdef TRIG_HYST_EN
            lowSeen_q   <= lowSeen_d;
            highSeen_q  <= highSeen_d;
`endif
        end
    end

    assign o_trigger    = trig_q;
    assign o_auto_trig  = autoTrig_q;
    assign o_armed      = (state_q == ARMED);
    assign o_busy       = (state_q != IDLE);
    assign o_state      = state_q;
    assign o_trig_count = trigCount_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Self-checking bench for trigger_ctrl: directed scenarios plus a randomized run against a
// queue-based behavioural model. Build with +define+TRIG_HYST_EN to exercise hysteresis.
module tb_trigger_ctrl;

    localparam int SW       = 12;
    localparam int PRETRIG  = 4;
    localparam int HOLDOFF  = 3;
    localparam int AUTO     = 20;
    localparam int HYST     = 16;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [11:0] data;
    logic [11:0] level;
    logic        slope;
    logic [1:0]  mode;
    logic        arm;
    logic        done;
    logic        o_trigger;
    logic        o_auto_trig;
    logic        o_armed;
    logic        o_busy;
    logic [2:0]  o_state;
    logic [15:0] o_trig_count;

    int checks;
    int failures;

    // Behavioural model state: phase as the debug encoding, plus plain counters and a sample log.
    int          mState;
    logic        mTrig;
    logic        mAuto;
    logic [15:0] mCount;
    int          mPre;
    int          mAge;
    int          mHoldLeft;
    logic [11:0] mSamples[$];

    trigger_ctrl #(
        .SAMPLE_WIDTH  (SW),
        .PRETRIG       (PRETRIG),
        .HOLDOFF_CYCLES(HOLDOFF),
        .AUTO_TIMEOUT  (AUTO),
        .HYST          (HYST)
    ) dut (
        .i_clk          (clk),
        .i_RESET        (rst),
        .i_sample_valid (valid),
        .i_sample_data  (data),
        .i_trig_level   (level),
        .i_trig_slope   (slope),
        .i_mode         (mode),
        .i_arm          (arm),
        .i_transfer_done(done),
        .o_trigger      (o_trigger),
        .o_auto_trig    (o_auto_trig),
        .o_armed        (o_armed),
        .o_busy         (o_busy),
        .o_state        (o_state),
        .o_trig_count   (o_trig_count)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic modelStep();
        logic edgeHit;
        logic [11:0] prv;
`ifdef TRIG_HYST_EN
        int lo;
        int hi;
        logic qual;
`endif
        mTrig = 1'b0;
        mAuto = 1'b0;
        if (rst) begin
            mState = 0; mCount = 16'd0; mPre = 0; mAge = 0; mHoldLeft = 0;
            mSamples.delete();
            return;
        end
        case (mState)
            0: if (mode == 2'd1 || mode == 2'd2 || (mode == 2'd3 && arm)) begin
                   mState = 1; mPre = 0;
               end
            1: if (mode == 2'd0) mState = 0;
               else if (valid) begin
                   mPre++;
                   if (mPre == PRETRIG) begin mState = 2; mAge = 0; mSamples.delete(); end
               end
            2: if (mode == 2'd0) mState = 0;
               else begin
                   edgeHit = 1'b0;
                   if (valid) begin
                       mSamples.push_back(data);
                       if (mSamples.size() >= 2) begin
                           prv = mSamples[mSamples.size() - 2];
                           if (!slope) edgeHit = (prv < level) && (data >= level);
                           else        edgeHit = (prv > level) && (data <= level);
`ifdef TRIG_HYST_EN
                           lo = int'(level) - HYST; if (lo < 0) lo = 0;
                           hi = int'(level) + HYST; if (hi > 4095) hi = 4095;
                           qual = 1'b0;
                           foreach (mSamples[i]) begin
                               if (!slope && int'(mSamples[i]) <= lo) qual = 1'b1;
                               if (slope && int'(mSamples[i]) >= hi) qual = 1'b1;
                           end
                           edgeHit = edgeHit && qual;
`endif
                       end
                   end
                   if (edgeHit || (mode == 2'd2 && mAge >= AUTO - 1)) begin
                       mTrig = 1'b1; mAuto = !edgeHit; mCount = mCount + 16'd1; mState = 3;
                   end
                   mAge++;
               end
            3: if (done) begin mState = 4; mHoldLeft = HOLDOFF; end
            4: if (mode == 2'd0) mState = 0;
               else begin
                   mHoldLeft--;
                   if (mHoldLeft == 0) begin
                       if (mode == 2'd1 || mode == 2'd2) begin mState = 1; mPre = 0; end
                       else mState = 0;
                   end
               end
            default: mState = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".trig"},  32'(o_trigger),    32'(mTrig));
        checkOne({tag, ".auto"},  32'(o_auto_trig),  32'(mAuto));
        checkOne({tag, ".armed"}, 32'(o_armed),      32'(mState == 2));
        checkOne({tag, ".busy"},  32'(o_busy),       32'(mState != 0));
        checkOne({tag, ".state"}, 32'(o_state),      32'(mState));
        checkOne({tag, ".count"}, 32'(o_trig_count), 32'(mCount));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [11:0] d);
        valid = v;
        data  = d;
        tick();
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1; mode = 2'd0; valid = 1'b0; arm = 1'b0; done = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput(tag);
        checkOne({tag, ".stateZero"}, 32'(o_state), 32'd0);
        checkOne({tag, ".countZero"}, 32'(o_trig_count), 32'd0);
    endtask

    initial begin
        int n;
        int v;
        logic expA;
        checks = 0; failures = 0;
        rst = 1'b1; valid = 1'b0; data = 12'h000; level = 12'h800; slope = 1'b0;
        mode = 2'd0; arm = 1'b0; done = 1'b0;
        mState = 0; mTrig = 1'b0; mAuto = 1'b0; mCount = 16'd0;
        mPre = 0; mAge = 0; mHoldLeft = 0;

        // NORMAL rising crossing, then transfer and holdoff back to PREFILL.
        doReset("rst1");
        level = 12'h800; slope = 1'b0; mode = 2'd1;
        applyStimulus("s1.enter", 1'b0, 12'h000);
        checkOne("s1.prefill", 32'(o_state), 32'd1);
        repeat (5) applyStimulus("s1.low", 1'b1, 12'h100);
        checkOne("s1.armed", 32'(o_armed), 32'd1);
        applyStimulus("s1.7ff", 1'b1, 12'h7FF);
        checkOne("s1.noTrig", 32'(o_trigger), 32'd0);
        applyStimulus("s1.800", 1'b1, 12'h800);
        checkOne("s1.trig", 32'(o_trigger), 32'd1);
        checkOne("s1.auto", 32'(o_auto_trig), 32'd0);
        checkOne("s1.state", 32'(o_state), 32'd3);
        checkOne("s1.count", 32'(o_trig_count), 32'd1);
        applyStimulus("s1.after", 1'b0, 12'h000);
        checkOne("s1.pulse", 32'(o_trigger), 32'd0);
        done = 1'b1;
        applyStimulus("s1.done", 1'b0, 12'h000);
        done = 1'b0;
        checkOne("s1.hold1", 32'(o_state), 32'd4);
        applyStimulus("s1.h2", 1'b0, 12'h000);
        applyStimulus("s1.h3", 1'b0, 12'h000);
        checkOne("s1.hold3", 32'(o_state), 32'd4);
        applyStimulus("s1.rearm", 1'b0, 12'h000);
        checkOne("s1.rearm", 32'(o_state), 32'd1);

        // AUTO timeout on a flat signal.
        doReset("rst2");
        mode = 2'd2;
        applyStimulus("s2.enter", 1'b0, 12'h000);
        repeat (PRETRIG) applyStimulus("s2.pre", 1'b1, 12'h100);
        checkOne("s2.armed", 32'(o_state), 32'd2);
        n = 0;
        while (o_trigger !== 1'b1 && n < 40) begin
            applyStimulus("s2.flat", 1'b1, 12'h100);
            n++;
        end
        checkOne("s2.latency", 32'(n), 32'd20);
        checkOne("s2.auto", 32'(o_auto_trig), 32'd1);
        checkOne("s2.count", 32'(o_trig_count), 32'd1);

        // SINGLE: needs arm, returns to IDLE after holdoff and stays there.
        doReset("rst3");
        mode = 2'd3;
        applyStimulus("s3.noArm", 1'b0, 12'h000);
        checkOne("s3.idle", 32'(o_state), 32'd0);
        arm = 1'b1;
        applyStimulus("s3.arm", 1'b0, 12'h000);
        arm = 1'b0;
        checkOne("s3.prefill", 32'(o_state), 32'd1);
        repeat (PRETRIG) applyStimulus("s3.pre", 1'b1, 12'h100);
        applyStimulus("s3.low", 1'b1, 12'h100);
        applyStimulus("s3.high", 1'b1, 12'h900);
        checkOne("s3.trig", 32'(o_trigger), 32'd1);
        done = 1'b1;
        applyStimulus("s3.done", 1'b0, 12'h000);
        done = 1'b0;
        applyStimulus("s3.h2", 1'b0, 12'h000);
        applyStimulus("s3.h3", 1'b0, 12'h000);
        checkOne("s3.hold3", 32'(o_state), 32'd4);
        applyStimulus("s3.exit", 1'b0, 12'h000);
        checkOne("s3.idle2", 32'(o_state), 32'd0);
        applyStimulus("s3.low2", 1'b1, 12'h100);
        applyStimulus("s3.high2", 1'b1, 12'h900);
        checkOne("s3.noTrig", 32'(o_trigger), 32'd0);
        checkOne("s3.count", 32'(o_trig_count), 32'd1);

        // STOP during WAIT_XFER, then reset in the middle of PREFILL.
        doReset("rst4");
        mode = 2'd1;
        applyStimulus("s4.enter", 1'b0, 12'h000);
        repeat (PRETRIG) applyStimulus("s4.pre", 1'b1, 12'h100);
        applyStimulus("s4.low", 1'b1, 12'h100);
        applyStimulus("s4.high", 1'b1, 12'h900);
        checkOne("s4.trig", 32'(o_trigger), 32'd1);
        mode = 2'd0;
        repeat (3) applyStimulus("s4.wait", 1'b1, 12'h100);
        checkOne("s4.stillWait", 32'(o_state), 32'd3);
        done = 1'b1;
        applyStimulus("s4.done", 1'b0, 12'h000);
        done = 1'b0;
        checkOne("s4.hold", 32'(o_state), 32'd4);
        applyStimulus("s4.stop", 1'b0, 12'h000);
        checkOne("s4.idle", 32'(o_state), 32'd0);
        mode = 2'd1;
        applyStimulus("s4.enter2", 1'b0, 12'h000);
        applyStimulus("s4.pre2", 1'b1, 12'h100);
        checkOne("s4.midPrefill", 32'(o_state), 32'd1);
        rst = 1'b1;
        applyStimulus("s4.rst", 1'b1, 12'h900);
        rst = 1'b0;
        checkOne("s4.rstState", 32'(o_state), 32'd0);
        checkOne("s4.rstBusy", 32'(o_busy), 32'd0);
        checkOne("s4.rstCount", 32'(o_trig_count), 32'd0);

        // Hysteresis: a shallow dip must not qualify when the band is enabled.
`ifdef TRIG_HYST_EN
        expA = 1'b0;
`else
        expA = 1'b1;
`endif
        doReset("rst5");
        mode = 2'd1;
        applyStimulus("s5.enter", 1'b0, 12'h000);
        repeat (PRETRIG) applyStimulus("s5.pre", 1'b1, 12'h7F8);
        applyStimulus("s5.shallow", 1'b1, 12'h7F8);
        applyStimulus("s5.cross", 1'b1, 12'h800);
        checkOne("s5.shallowTrig", 32'(o_trigger), 32'(expA));
        doReset("rst5b");
        mode = 2'd1;
        applyStimulus("s5.enter2", 1'b0, 12'h000);
        repeat (PRETRIG) applyStimulus("s5.pre2", 1'b1, 12'h7F8);
        applyStimulus("s5.deep", 1'b1, 12'h7E0);
        applyStimulus("s5.cross2", 1'b1, 12'h800);
        checkOne("s5.deepTrig", 32'(o_trigger), 32'd1);

        // Edge and timeout on the same cycle give one non-auto pulse.
        doReset("rst6");
        mode = 2'd2;
        applyStimulus("s6.enter", 1'b0, 12'h000);
        repeat (PRETRIG) applyStimulus("s6.pre", 1'b1, 12'h100);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus("s6.run", (k == 5 || k == 20), (k == 20) ? 12'h900 : 12'h100);
            if (k < 20) checkOne("s6.early", 32'(o_trigger), 32'd0);
        end
        checkOne("s6.trig", 32'(o_trigger), 32'd1);
        checkOne("s6.auto", 32'(o_auto_trig), 32'd0);
        checkOne("s6.count", 32'(o_trig_count), 32'd1);
        applyStimulus("s6.after", 1'b0, 12'h000);
        checkOne("s6.single", 32'(o_trigger), 32'd0);

        // Randomized traffic against the model.
        for (int run = 0; run < 4; run++) begin
            doReset("rrst");
            level = 12'($urandom_range(12'h100, 12'hE00));
            slope = 1'($urandom_range(0, 1));
            mode  = 2'd1;
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
                arm  = ($urandom_range(0, 9) == 0);
                done = ($urandom_range(0, 5) == 0);
                rst  = ($urandom_range(0, 799) == 0);
                v = int'(level) + int'($urandom_range(0, 96)) - 48;
                applyStimulus("rand", 1'($urandom_range(0, 1)), 12'(v));
            end
            rst = 1'b0; arm = 1'b0; done = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
